// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch resolution controller.
// Holds the FSM state enum, branch funct3 codes and the 2-bit predictor encoding.
package branch_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RESET = WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side bundle for the branch resolution controller.
// master = pipeline/compare unit/fetch, slave = the controller.
interface branch_resolve_ctrl_if #(parameter int XLEN = 32);
    logic            ex_valid;
    logic            ex_stall;
    logic            ex_branch;
    logic            ex_jal;
    logic            ex_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            ex_pred_taken;
    logic [2:0]      br_ctrl;
    logic            br_out;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic            flush_exmem;
    logic            exc_misaligned;
    logic [XLEN-1:0] exc_pc;
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;

    modport master (
        output ex_valid, ex_stall, ex_branch, ex_jal, ex_jalr, ex_funct3,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, br_out, if_pc,
        input  br_ctrl, if_pred_taken, redirect_valid, redirect_pc,
               flush_ifid, flush_idex, flush_exmem, exc_misaligned, exc_pc,
               br_count, mispred_count
    );

    modport slave (
        input  ex_valid, ex_stall, ex_branch, ex_jal, ex_jalr, ex_funct3,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, br_out, if_pc,
        output br_ctrl, if_pred_taken, redirect_valid, redirect_pc,
               flush_ifid, flush_idex, flush_exmem, exc_misaligned, exc_pc,
               br_count, mispred_count
    );
endinterface

// File: rtl/branch_resolve_ctrl_bht.sv
// 2-bit saturating direction predictor table.
// Combinational read returns the pre-write value when read and write hit one index.
module branch_history_table
    import branch_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] table_q [ENTRIES];

    assign rd_taken = table_q[rd_idx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_RESET;
        end else if (wr_en) begin
            table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/jump resolver: issues registered redirects and flushes,
// raises misaligned-target exceptions, trains the BHT and keeps statistics.
//
//  state    | meaning
//  RUN      | resolving EX instructions normally
//  REDIRECT | redirect/flush cycle; EX holds a wrong-path instruction, ignore it
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    state_t          state;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;
    logic            exc_q;
    logic [XLEN-1:0] exc_pc_q;
    logic [31:0]     br_count_q;
    logic [31:0]     mispred_count_q;

    logic            is_jump;
    logic            legal_br;
    logic            counted;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fix_pc;
    logic            misaligned;
    logic            mispredict;
    logic            bht_we;

    wire unused_if_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

    always_comb begin
        is_jump    = bus.ex_jal | bus.ex_jalr;
        legal_br   = bus.ex_funct3 inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
        counted    = (state == RUN) && bus.ex_valid && !bus.ex_stall &&
                     (is_jump || (bus.ex_branch && legal_br));
        taken      = is_jump | bus.br_out;
        target     = bus.ex_jalr ? ((bus.ex_rs1 + bus.ex_imm) & ~XLEN'(1))
                                 : (bus.ex_pc + bus.ex_imm);
        fix_pc     = taken ? target : bus.ex_pc + XLEN'(4);
        // A faulting taken target never redirects; the exception path owns fetch.
        misaligned = counted && taken && target[1];
        mispredict = counted && !misaligned && (is_jump || (taken != bus.ex_pred_taken));
        bht_we     = counted && !is_jump;
    end

    branch_history_table #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (bus.if_pc[IDX_W+1:2]),
        .rd_taken (bus.if_pred_taken),
        .wr_en    (bht_we),
        .wr_idx   (bus.ex_pc[IDX_W+1:2]),
        .wr_taken (bus.br_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            exc_q            <= 1'b0;
            exc_pc_q         <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            exc_q            <= 1'b0;
            exc_pc_q         <= '0;
            case (state)
                RUN: begin
                    if (mispredict) begin
                        state            <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= fix_pc;
                        flush_q          <= 1'b1;
                        if (mispred_count_q != '1) mispred_count_q <= mispred_count_q + 32'd1;
                    end else if (misaligned) begin
                        exc_q         <= 1'b1;
                        exc_pc_q      <= bus.ex_pc;
                        redirect_pc_q <= target;
                    end
                    if (counted && br_count_q != '1) br_count_q <= br_count_q + 32'd1;
                end
                REDIRECT: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    assign bus.br_ctrl        = bus.ex_funct3;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_ifid     = flush_q;
    assign bus.flush_idex     = flush_q;
    assign bus.flush_exmem    = flush_q;
    assign bus.exc_misaligned = exc_q;
    assign bus.exc_pc         = exc_pc_q;
    assign bus.br_count       = br_count_q;
    assign bus.mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a reference model pushes expected
// registered outputs to a scoreboard each cycle; they are popped after the edge.
module tb_branch_resolve_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

    branch_resolve_ctrl #(.XLEN(XLEN), .BHT_ENTRIES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        exc;
        logic [31:0] epc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_redirect;
    logic [1:0]  m_bht [16];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic st, input logic b, input logic j,
                          input logic jr, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic pred, input logic bo);
        bus.ex_valid = v;   bus.ex_stall = st;  bus.ex_branch = b;
        bus.ex_jal = j;     bus.ex_jalr = jr;   bus.ex_funct3 = f3;
        bus.ex_pc = pc;     bus.ex_imm = imm;   bus.ex_rs1 = rs1;
        bus.ex_pred_taken = pred;               bus.br_out = bo;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask

    // One clock: model the cycle, queue expectation, clock the DUT, compare.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        g;
        logic        jump;
        logic        tk;
        logic [31:0] tgt;
        logic [3:0]  idx;
        #2;
        check_val({tag, ".br_ctrl"}, 32'(bus.br_ctrl), 32'(bus.ex_funct3));
        e = '{rv: 0, rpc: 0, fl: 0, exc: 0, epc: 0, bc: 0, mc: 0};
        if (reset) begin
            m_redirect = 0;
            m_br = 0;
            m_mis = 0;
            for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        end else if (m_redirect) begin
            m_redirect = 0;
        end else if (bus.ex_valid && !bus.ex_stall && (bus.ex_branch || bus.ex_jal || bus.ex_jalr)) begin
            jump = bus.ex_jal || bus.ex_jalr;
            if (jump || !(bus.ex_funct3 == 3'b010 || bus.ex_funct3 == 3'b011)) begin
                tk  = jump ? 1'b1 : bus.br_out;
                tgt = bus.ex_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE) : (bus.ex_pc + bus.ex_imm);
                if (m_br != 32'hFFFF_FFFF) m_br++;
                if (!jump) begin
                    idx = bus.ex_pc[5:2];
                    if (tk && m_bht[idx] != 2'b11) m_bht[idx]++;
                    if (!tk && m_bht[idx] != 2'b00) m_bht[idx]--;
                end
                if (tk && tgt[1]) begin
                    e.exc = 1; e.epc = bus.ex_pc; e.rpc = tgt;
                end else if (jump || tk != bus.ex_pred_taken) begin
                    e.rv = 1; e.fl = 1; e.rpc = tk ? tgt : bus.ex_pc + 32'd4;
                    if (m_mis != 32'hFFFF_FFFF) m_mis++;
                    m_redirect = 1;
                end
            end
        end
        e.bc = m_br;
        e.mc = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_val({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(g.rv));
        check_val({tag, ".flush_ifid"},     32'(bus.flush_ifid),     32'(g.fl));
        check_val({tag, ".flush_idex"},     32'(bus.flush_idex),     32'(g.fl));
        check_val({tag, ".flush_exmem"},    32'(bus.flush_exmem),    32'(g.fl));
        check_val({tag, ".exc_misaligned"}, 32'(bus.exc_misaligned), 32'(g.exc));
        check_val({tag, ".br_count"},       bus.br_count,            g.bc);
        check_val({tag, ".mispred_count"},  bus.mispred_count,       g.mc);
        if (g.rv || g.exc) check_val({tag, ".redirect_pc"}, bus.redirect_pc, g.rpc);
        if (g.exc || reset) check_val({tag, ".exc_pc"}, bus.exc_pc, g.epc);
        if (reset) check_val({tag, ".redirect_pc_rst"}, bus.redirect_pc, 32'h0);
        check_val({tag, ".if_pred_taken"}, 32'(bus.if_pred_taken), 32'(m_bht[bus.if_pc[5:2]][1]));
    endtask

    initial begin
        m_redirect = 0;
        m_br = 0;
        m_mis = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        reset = 1;
        bus.if_pc = 32'h100;
        idle();
        @(posedge clk);
        #1;
        step("reset0");
        step("reset1");
        reset = 0;

        // BEQ mispredicted taken, then the REDIRECT cycle
        set_in(1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 0, 1);
        step("beq_taken");
        idle();
        step("beq_redir");

        bus.if_pc = 32'h200;
        set_in(1, 0, 1, 0, 0, 3'b001, 32'h200, 32'h40, 32'h0, 1, 0);
        step("bne_nt_mis");
        idle();
        step("bne_redir");
        set_in(1, 0, 1, 0, 0, 3'b001, 32'h200, 32'h40, 32'h0, 1, 1);
        step("bne_tk_ok");

        // JALR misaligned target, then aligned, then wrong-path branch in REDIRECT
        set_in(1, 0, 0, 0, 1, 3'b000, 32'h500, 32'h0, 32'h1003, 0, 0);
        step("jalr_misal");
        set_in(1, 0, 0, 0, 1, 3'b000, 32'h504, 32'h0, 32'h1001, 0, 0);
        step("jalr_ok");
        set_in(1, 0, 1, 0, 0, 3'b000, 32'h508, 32'h10, 32'h0, 0, 1);
        step("wrong_path");
        idle();
        step("after_wp");

        // Saturation at pc 0x40 (shares index 0 with 0x100)
        bus.if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 0, 0, 3'b000, 32'h40, 32'h8, 32'h0, 1, 1);
            step("sat_up");
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 1, 0, 0, 3'b000, 32'h40, 32'h8, 32'h0, 0, 0);
            step("sat_dn");
        end

        // Illegal funct3 and not-taken branch with misaligned target
        set_in(1, 0, 1, 0, 0, 3'b010, 32'h40, 32'h8, 32'h0, 1, 1);
        step("illegal_f3");
        set_in(1, 0, 1, 0, 0, 3'b000, 32'h44, 32'h2, 32'h0, 0, 0);
        step("nt_misal");
        set_in(1, 0, 1, 0, 0, 3'b000, 32'h44, 32'h2, 32'h0, 0, 1);
        step("tk_misal_br");

        // Priority jalr > jal > branch
        set_in(1, 0, 1, 1, 1, 3'b000, 32'h600, 32'h10, 32'h2000, 0, 0);
        step("prio_jalr");
        idle();
        step("prio_redir");

        // Stall holds off resolution
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 0, 0, 3'b101, 32'h700, 32'h40, 32'h0, 0, 1);
            step("stalled");
        end
        set_in(1, 0, 1, 0, 0, 3'b101, 32'h700, 32'h40, 32'h0, 0, 1);
        step("unstalled");

        // Reset during REDIRECT
        set_in(1, 0, 1, 0, 0, 3'b110, 32'h100, 32'h20, 32'h0, 0, 1);
        step("pre_rst_br");
        set_in(1, 0, 0, 1, 0, 3'b000, 32'h300, 32'h10, 32'h0, 0, 0);
        reset = 1;
        step("rst_in_redir");
        reset = 0;
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.if_pc = 32'(i * 4);
            step("bht_rst_scan");
        end
        bus.if_pc = 32'h80;
        set_in(1, 0, 1, 0, 0, 3'b111, 32'h80, 32'h8, 32'h0, 1, 1);
        step("bht_01_to_10");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            bus.if_pc = {24'h0, 4'($urandom), 4'($urandom) & 4'hC};
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, f3,
                   {20'h0, 10'($urandom), 2'b00}, {24'h0, 6'($urandom), 2'($urandom)},
                   $urandom, 1'($urandom), 1'($urandom));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
